ahb_peri_master: RTL and testbench

AHB-Lite single-transfer initiator that drives the peripheral (AHB-to-APB) bridge port from a simple valid/ready command interface.
- Buffers commands in a small FIFO and issues one word transfer at a time.
- Handles wait states, the two-cycle ERROR response and hung slaves via a timeout.
- Returns read data and status on a valid/ready response interface.
- Sits between the CPU-side peripheral request logic / debug loader and the bridge's hsel/mas_send/slv_send port.

---
 rtl/AHB_package.sv | 37 +++
 rtl/ahb_peri_master_pkg.sv | 26 ++
 rtl/ahb_peri_master_fifo.sv | 48 ++++
 rtl/ahb_peri_master.sv | 113 +++++++++++
 tb/tb_ahb_peri_master.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/AHB_package.sv
// AHB_package: shared AHB-Lite encodings and bus bundles for the peripheral bridge port
//   mas_send_type : initiator -> bridge address/control/write data
//   slv_send_type : bridge -> initiator hreadyout/hresp/hrdata
//   ahbm_cmd_type : single-word command queued by ahb_peri_master
package AHB_package;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] PERI_HPROT    = 4'b0011;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        logic [1:0]  htrans;
        logic        hmastlock;
        logic        hready;
        logic [31:0] hwdata;
    } mas_send_type;

    typedef struct packed {
        logic        hreadyout;
        logic        hresp;
        logic [31:0] hrdata;
    } slv_send_type;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ahbm_cmd_type;

endpackage

// File: rtl/ahb_peri_master_pkg.sv
// ahb_peri_master_pkg: FSM state encodings and issue-beat builder for ahb_peri_master
package ahb_peri_master_pkg;

    import AHB_package::*;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ERR2  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    function automatic mas_send_type issue_beat(input ahbm_cmd_type c);
        mas_send_type m;
        m        = '0;
        m.haddr  = c.addr;
        m.hwrite = c.write;
        m.hwdata = c.wdata;
        m.htrans = HTRANS_NONSEQ;
        m.hsize  = HSIZE_WORD;
        m.hburst = HBURST_SINGLE;
        m.hprot  = PERI_HPROT;
        return m;
    endfunction

endpackage

// File: rtl/ahb_peri_master_fifo.sv
// sync_fifo: single-clock FIFO of any packed type with full/empty flags
//   ahb_clk, rst_n : clock, async active-low reset
//   push, din      : write when not full (or when full and popping in the same cycle)
//   pop, dout      : dout shows the head entry; pop advances it
//   full, empty    : occupancy flags, derived from the registered count
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic ahb_clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    count;
    logic           wr, rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rp];

    // power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge ahb_clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end

    always_ff @(posedge ahb_clk)
        if (wr) mem[wp] <= din;

endmodule

// File: rtl/ahb_peri_master.sv
// ahb_peri_master: AHB-Lite single-transfer initiator for the AHB-to-APB bridge port
//   ahb_clk, rst_n                  : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata: command input, buffered in a FIFO
//   rsp_valid/ready/rdata/err/timeout: response output, one per command, in order
//   hsel_peri, peri_out, peri_in    : bridge select pulse and bus bundles
//   busy                            : transfer in flight or command queued
module ahb_peri_master
    import AHB_package::*, ahb_peri_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 255,
    parameter int TURNAROUND = 2
) (
    input  logic                      ahb_clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      hsel_peri,
    output AHB_package::mas_send_type peri_out,
    input  AHB_package::slv_send_type peri_in,
    output logic                      busy
);

    logic [2:0]   state;
    logic [7:0]   cnt;
    logic         full, empty, pop;
    ahbm_cmd_type head, cmd_in;
    logic         in_wait, in_err2, last, gap_last;
    logic         ok_done, err_done, go_err2, tmo;

    assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata};
    assign cmd_ready = !full;
    assign pop       = state == ST_IDLE && !empty && !rsp_valid;
    assign busy      = state != ST_IDLE || !empty;

    sync_fifo #(.T(ahbm_cmd_type), .DEPTH(FIFO_DEPTH)) u_fifo (
        .ahb_clk (ahb_clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .pop     (pop),
        .din     (cmd_in),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    // cnt counts data-phase cycles in WAIT/ERR2 and turnaround cycles in GAP
    assign in_wait  = state == ST_WAIT;
    assign in_err2  = state == ST_ERR2;
    assign last     = int'(cnt) + 1 >= TIMEOUT;
    assign gap_last = int'(cnt) + 1 >= TURNAROUND;
    assign ok_done  = in_wait && peri_in.hreadyout && !peri_in.hresp;
    assign err_done = (in_wait && peri_in.hreadyout && peri_in.hresp) || (in_err2 && peri_in.hreadyout);
    assign tmo      = (in_wait || in_err2) && !peri_in.hreadyout && last;
    assign go_err2  = in_wait && peri_in.hresp && !peri_in.hreadyout && !last;

    always_ff @(posedge ahb_clk or negedge rst_n)
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hsel_peri   <= 1'b0;
            peri_out    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (pop) begin
                        state     <= ST_ISSUE;
                        hsel_peri <= 1'b1;
                        peri_out  <= issue_beat(head);
                    end
                ST_ISSUE: begin
                    state     <= ST_WAIT;
                    hsel_peri <= 1'b0;
                    cnt       <= '0;
                end
                ST_WAIT, ST_ERR2:
                    if (ok_done || err_done || tmo) begin
                        state       <= ST_RESP;
                        peri_out    <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= (ok_done && !peri_out.hwrite) ? peri_in.hrdata : '0;
                        rsp_err     <= !ok_done;
                        rsp_timeout <= tmo;
                    end else begin
                        if (go_err2) state <= ST_ERR2;
                        cnt <= cnt + 8'd1;
                    end
                ST_RESP:
                    if (rsp_ready) begin
                        state     <= ST_GAP;
                        rsp_valid <= 1'b0;
                        cnt       <= '0;
                    end
                ST_GAP:
                    if (gap_last) state <= ST_IDLE;
                    else cnt <= cnt + 8'd1;
                default: state <= ST_IDLE;
            endcase
        end

endmodule

// File: tb/tb_ahb_peri_master.sv
// tb_ahb_peri_master: directed vectors and corner-case sequences for ahb_peri_master
module tb_ahb_peri_master;

    import AHB_package::*;

    localparam int TURNAROUND = 2;

    logic         ahb_clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [31:0]  cmd_addr, cmd_wdata;
    logic         rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0]  rsp_rdata;
    logic         hsel_peri, busy;
    mas_send_type peri_out;
    slv_send_type peri_in;

    int total = 0;
    int bad   = 0;

    ahb_peri_master #(.FIFO_DEPTH(2), .TIMEOUT(255), .TURNAROUND(TURNAROUND)) dut (
        .ahb_clk     (ahb_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .hsel_peri   (hsel_peri),
        .peri_out    (peri_out),
        .peri_in     (peri_in),
        .busy        (busy)
    );

    always #5 ahb_clk = ~ahb_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        int          mode;
        logic [31:0] hrd;
        logic [31:0] er;
        logic        ee;
        logic        et;
    } vec_t;

    vec_t vecs [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkbus(input string name, input mas_send_type act, input mas_send_type exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(negedge ahb_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_hsel(output int idle);
        idle = 0;
        while (!hsel_peri && idle < 40) begin
            @(negedge ahb_clk);
            idle++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge ahb_clk);
            k++;
        end
        chk1("idle", busy, 1'b0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge ahb_clk);
        rsp_ready = 1'b0;
    endtask

    // called at the negedge where hsel_peri is high; plays the slave and checks the response
    task automatic serve_check(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input int lat, input int mode, input logic [31:0] hrd,
                               input logic [31:0] er, input logic ee, input logic et);
        mas_send_type exp;
        int n;
        exp        = '0;
        exp.haddr  = a;
        exp.hwrite = w;
        exp.hwdata = d;
        exp.htrans = 2'b10;
        exp.hsize  = 3'b010;
        exp.hburst = 3'b000;
        exp.hprot  = 4'b0011;
        chk1("issue_hsel", hsel_peri, 1'b1);
        chkbus("issue_fields", peri_out, exp);
        n = lat + 1 + ((mode == 1) ? 1 : 0);
        for (int k = 0; k < n; k++) begin
            @(negedge ahb_clk);
            chk1("hsel_pulse", hsel_peri, 1'b0);
            chkbus("hold", peri_out, exp);
            chk1("no_early_rsp", rsp_valid, 1'b0);
            peri_in.hrdata    = hrd;
            peri_in.hreadyout = (mode == 1) ? (k == lat + 1) : (k == lat);
            peri_in.hresp     = (mode == 1) ? (k >= lat) : (mode == 2 && k == lat);
        end
        @(negedge ahb_clk);
        peri_in = '0;
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk32("rsp_rdata", rsp_rdata, er);
        chk1("rsp_err", rsp_err, ee);
        chk1("rsp_timeout", rsp_timeout, et);
        chkbus("bus_idle", peri_out, '0);
    endtask

    initial begin
        int idle, n;
        logic ok;
        mas_send_type zero_bus;
        zero_bus  = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        peri_in   = '0;

        vecs[0] = '{1'b1, 32'h0001_0104, 32'hA5A5_5A5A, 5, 0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0001_0108, 32'h0000_0000, 2, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0001_0200, 32'h0000_0000, 0, 1, 32'hDEAD_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0001_0300, 32'h0000_0000, 1, 2, 32'hBEEF_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0001_0003, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0001_0010, 32'h0F0F_1234, 1, 0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0001_0020, 32'h5555_AAAA, 2, 1, 32'h7777_7777, 32'h0000_0000, 1'b1, 1'b0};

        repeat (2) @(negedge ahb_clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_hsel", hsel_peri, 1'b0);
        chkbus("rst_bus", peri_out, zero_bus);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge ahb_clk);

        foreach (vecs[i]) begin
            push_cmd(vecs[i].w, vecs[i].a, vecs[i].d);
            wait_hsel(idle);
            serve_check(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].mode,
                        vecs[i].hrd, vecs[i].er, vecs[i].ee, vecs[i].et);
            @(negedge ahb_clk);
            chk1("rsp_stable_valid", rsp_valid, 1'b1);
            chk32("rsp_stable_rdata", rsp_rdata, vecs[i].er);
            handshake();
            chk1("rsp_drop", rsp_valid, 1'b0);
            wait_idle();
        end

        // hung slave: 255 data-phase cycles then forced abort; late hreadyout in GAP ignored
        push_cmd(1'b0, 32'h0001_0400, 32'h0);
        wait_hsel(idle);
        chk1("to_issue", hsel_peri, 1'b1);
        n = 0;
        do begin
            @(negedge ahb_clk);
            n++;
        end while (!rsp_valid && n < 400);
        chk32("to_cycles", 32'(n), 32'd256);
        chk1("to_valid", rsp_valid, 1'b1);
        chk1("to_err", rsp_err, 1'b1);
        chk1("to_flag", rsp_timeout, 1'b1);
        chk32("to_rdata", rsp_rdata, 32'h0);
        handshake();
        peri_in.hreadyout = 1'b1;
        peri_in.hrdata    = 32'hCAFE_F00D;
        ok = 1'b1;
        repeat (5) begin
            @(negedge ahb_clk);
            if (rsp_valid || hsel_peri) ok = 1'b0;
        end
        peri_in = '0;
        chk1("late_ready_ignored", ok, 1'b1);
        chk1("to_idle", busy, 1'b0);

        // three back-to-back commands into a 2-deep FIFO with responses held off
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0001_1000;
        @(negedge ahb_clk);
        cmd_addr = 32'h0001_1004;
        @(negedge ahb_clk);
        chk1("q_issue_a", hsel_peri, 1'b1);
        chk32("q_addr_a", peri_out.haddr, 32'h0001_1000);
        cmd_addr = 32'h0001_1008;
        @(negedge ahb_clk);
        cmd_valid = 1'b0;
        chk1("q_full", cmd_ready, 1'b0);
        peri_in.hreadyout = 1'b1;
        peri_in.hrdata    = 32'hAAAA_0001;
        @(negedge ahb_clk);
        peri_in = '0;
        chk1("q_rsp_a", rsp_valid, 1'b1);
        chk32("q_rdata_a", rsp_rdata, 32'hAAAA_0001);
        ok = 1'b1;
        repeat (10) begin
            @(negedge ahb_clk);
            if (hsel_peri || !rsp_valid || cmd_ready || rsp_rdata !== 32'hAAAA_0001) ok = 1'b0;
        end
        chk1("q_one_outstanding", ok, 1'b1);
        handshake();
        wait_hsel(idle);
        chk1("q_turnaround", hsel_peri && idle >= TURNAROUND, 1'b1);
        chk1("q_ready_again", cmd_ready, 1'b1);
        serve_check(1'b0, 32'h0001_1004, 32'h0, 0, 0, 32'hBBBB_0002, 32'hBBBB_0002, 1'b0, 1'b0);
        handshake();
        wait_hsel(idle);
        serve_check(1'b0, 32'h0001_1008, 32'h0, 1, 0, 32'hCCCC_0003, 32'hCCCC_0003, 1'b0, 1'b0);
        handshake();
        wait_idle();

        // reset during WAIT with another command queued
        push_cmd(1'b0, 32'h0001_2000, 32'h0);
        wait_hsel(idle);
        @(negedge ahb_clk);
        push_cmd(1'b1, 32'h0001_2004, 32'h1111_2222);
        chk1("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_cmd_ready", cmd_ready, 1'b1);
        chk1("arst_rsp_valid", rsp_valid, 1'b0);
        chk1("arst_hsel", hsel_peri, 1'b0);
        chkbus("arst_bus", peri_out, zero_bus);
        chk1("arst_busy", busy, 1'b0);
        chk32("arst_rdata", rsp_rdata, 32'h0);
        chk1("arst_err", rsp_err, 1'b0);
        chk1("arst_timeout", rsp_timeout, 1'b0);
        @(negedge ahb_clk);
        rst_n = 1'b1;
        peri_in.hreadyout = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge ahb_clk);
            if (rsp_valid || hsel_peri || busy) ok = 1'b0;
        end
        peri_in = '0;
        chk1("post_rst_quiet", ok, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
